// File: rtl/seconds_display_counter_if.sv
// Bundles the 1 Hz input, count controls and display outputs of seconds_display_counter.
// master drives the controls and observes the display; slave is the counter itself.
interface seconds_display_counter_if;
    logic        clk_1;
    logic        run;
    logic        clear;
    logic [15:0] count_bcd;
    logic        tick_1hz;
    logic        rollover;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    modport master (
        output clk_1, run, clear,
        input  count_bcd, tick_1hz, rollover, seg, an, dp
    );

    modport slave (
        input  clk_1, run, clear,
        output count_bcd, tick_1hz, rollover, seg, an, dp
    );
endinterface

// File: rtl/seconds_display_counter.sv
// MM:SS BCD counter enabled by a synchronised 1 Hz square wave, driving a
// 4-digit multiplexed active-low seven-segment display.
module seconds_display_counter #(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic                      clk_100M,
    input  logic                      rst_n,
    seconds_display_counter_if.slave  bus
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] REFRESH_TERM = CW'(REFRESH_DIV - 1);
    // Per-digit maximum, packed in the same nibble order as count_bcd.
    localparam logic [15:0] DIGIT_MAX = 16'h5959;

    // ------------------------------------------------------------------
    // clk_1 synchroniser and rising-edge detector
    // ------------------------------------------------------------------
    logic s1_reg;
    logic s2_reg;
    logic s3_reg;
    logic tick;

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= bus.clk_1;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign tick = s2_reg & ~s3_reg;

    // ------------------------------------------------------------------
    // BCD count: one carry-chained stage per digit
    // ------------------------------------------------------------------
    logic [15:0] count_reg;
    logic [15:0] count_next;
    logic [4:0]  carry;
    logic        rollover_reg;
    logic        rollover_next;

    assign carry[0] = tick & bus.run;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] MAX = DIGIT_MAX[gi*4 +: 4];
            logic [3:0] digit;
            logic       at_max;

            assign digit           = count_reg[gi*4 +: 4];
            assign at_max          = (digit == MAX);
            assign carry[gi+1]     = carry[gi] & at_max;
            assign count_next[gi*4 +: 4] =
                bus.clear ? 4'd0 :
                !carry[gi] ? digit :
                at_max     ? 4'd0 : digit + 4'd1;
        end
    endgenerate

    // A carry out of the top digit is exactly the 59:59 -> 00:00 wrap.
    assign rollover_next = carry[4] & ~bus.clear;

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= 16'h0000;
            rollover_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            rollover_reg <= rollover_next;
        end
    end

    // ------------------------------------------------------------------
    // Free-running digit scan
    // ------------------------------------------------------------------
    logic [CW-1:0] refresh_cnt_reg;
    logic [CW-1:0] refresh_cnt_next;
    logic [1:0]    digit_sel_reg;
    logic [1:0]    digit_sel_next;

    always_comb begin
        refresh_cnt_next = refresh_cnt_reg + CW'(1);
        digit_sel_next   = digit_sel_reg;
        if (refresh_cnt_reg == REFRESH_TERM) begin
            refresh_cnt_next = '0;
            digit_sel_next   = digit_sel_reg + 2'd1;
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt_reg <= '0;
            digit_sel_reg   <= 2'd0;
        end else begin
            refresh_cnt_reg <= refresh_cnt_next;
            digit_sel_reg   <= digit_sel_next;
        end
    end

    // ------------------------------------------------------------------
    // Display registers
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] code;
        case (value)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = 7'b1111111;
        endcase
        return code;
    endfunction

    logic [3:0] shown_digit;
    logic [6:0] seg_reg;
    logic [6:0] seg_next;
    logic [3:0] an_reg;
    logic [3:0] an_next;
    logic       dp_reg;
    logic       dp_next;

    always_comb begin
        shown_digit = count_reg[digit_sel_reg*4 +: 4];
        seg_next    = seg_decode(shown_digit);
        an_next     = ~(4'b0001 << digit_sel_reg);
        // The point after min_units forms the MM.SS separator.
        dp_next     = (digit_sel_reg != 2'd2);
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg <= 7'b1111111;
            an_reg  <= 4'b1111;
            dp_reg  <= 1'b1;
        end else begin
            seg_reg <= seg_next;
            an_reg  <= an_next;
            dp_reg  <= dp_next;
        end
    end

    assign bus.count_bcd = count_reg;
    assign bus.tick_1hz  = tick;
    assign bus.rollover  = rollover_reg;
    assign bus.seg       = seg_reg;
    assign bus.an        = an_reg;
    assign bus.dp        = dp_reg;

endmodule

// File: tb/tb_seconds_display_counter.sv
// Scoreboard bench for seconds_display_counter: every clk_1 pulse pushes the expected
// count/rollover, and a monitor checks them whenever tick_1hz fires.
module tb_seconds_display_counter;

    localparam int REFRESH_DIV = 4;

    logic clk_100M = 1'b0;
    logic rst_n    = 1'b0;

    seconds_display_counter_if bus ();

    seconds_display_counter #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 clk_100M = ~clk_100M;

    typedef struct packed {
        logic [15:0] count;
        logic        roll;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   sec    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int m;
        int ss;
        m  = s / 60;
        ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic exp_t next_exp(input bit counts);
        exp_t e;
        if (counts) begin
            e.roll = (sec == 3599);
            sec    = (sec + 1) % 3600;
        end else begin
            e.roll = 1'b0;
        end
        e.count = to_bcd(sec);
        return e;
    endfunction

    // One full clk_1 period; the count settles within 3 falling edges of the rise.
    task automatic do_tick();
        exp_q.push_back(next_exp(bus.run));
        bus.clk_1 = 1'b1;
        repeat (4) @(negedge clk_100M);
        bus.clk_1 = 1'b0;
        repeat (4) @(negedge clk_100M);
    endtask

    // Monitor: each tick must last one cycle and be followed by the expected count.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_100M);
            if (bus.tick_1hz === 1'b1) begin
                @(negedge clk_100M);
                check("tick_width", 32'(bus.tick_1hz), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_tick", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_count", 32'(bus.count_bcd), 32'(e.count));
                    check("sb_rollover", 32'(bus.rollover), 32'(e.roll));
                end
            end
        end
    end

    initial begin
        logic [3:0] scan_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] scan_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        logic [3:0] prev_an;
        bit         found;
        bit         saw_tick;

        bus.clk_1 = 1'b0;
        bus.run   = 1'b1;
        bus.clear = 1'b0;

        // Reset held while clk_1 toggles: nothing may move.
        repeat (3) @(negedge clk_100M);
        bus.clk_1 = 1'b1;
        repeat (3) @(negedge clk_100M);
        bus.clk_1 = 1'b0;
        repeat (3) @(negedge clk_100M);
        check("rst_count", 32'(bus.count_bcd), 32'h0000);
        check("rst_seg", 32'(bus.seg), 32'h7f);
        check("rst_an", 32'(bus.an), 32'hf);
        check("rst_dp", 32'(bus.dp), 32'd1);
        check("rst_tick", 32'(bus.tick_1hz), 32'd0);
        check("rst_roll", 32'(bus.rollover), 32'd0);

        rst_n = 1'b1;
        @(negedge clk_100M);
        check("post_rst_an", 32'(bus.an), 32'he);
        check("post_rst_seg", 32'(bus.seg), 32'h40);
        check("post_rst_dp", 32'(bus.dp), 32'd1);
        repeat (4) @(negedge clk_100M);

        // First tick with explicit latency checks.
        exp_q.push_back(next_exp(1'b1));
        bus.clk_1 = 1'b1;
        @(negedge clk_100M);
        check("lat_tick_k", 32'(bus.tick_1hz), 32'd0);
        @(negedge clk_100M);
        check("lat_tick_k1", 32'(bus.tick_1hz), 32'd1);
        check("lat_count_k1", 32'(bus.count_bcd), 32'h0000);
        @(negedge clk_100M);
        check("lat_count_k2", 32'(bus.count_bcd), 32'h0001);
        bus.clk_1 = 1'b0;
        saw_tick = 1'b0;
        repeat (6) begin
            @(negedge clk_100M);
            if (bus.tick_1hz) saw_tick = 1'b1;
        end
        check("fall_no_tick", 32'(saw_tick), 32'd0);

        // Carry chain.
        while (sec < 59) do_tick();
        check("cnt_0059", 32'(bus.count_bcd), 32'h0059);
        do_tick();
        check("cnt_0100", 32'(bus.count_bcd), 32'h0100);
        while (sec < 599) do_tick();
        check("cnt_0959", 32'(bus.count_bcd), 32'h0959);
        do_tick();
        check("cnt_1000", 32'(bus.count_bcd), 32'h1000);
        while (sec < 754) do_tick();
        check("cnt_1234", 32'(bus.count_bcd), 32'h1234);

        // Scan at 12:34: find the start of the sec_units slot, then walk 16 cycles.
        found   = 1'b0;
        prev_an = bus.an;
        for (int i = 0; i < 24 && !found; i++) begin
            @(negedge clk_100M);
            if (bus.an == 4'b1110 && prev_an == 4'b0111) found = 1'b1;
            prev_an = bus.an;
        end
        check("scan_sync", 32'(found), 32'd1);
        if (found) begin
            for (int i = 0; i < 16; i++) begin
                check("scan_an", 32'(bus.an), 32'(scan_an[i/4]));
                check("scan_seg", 32'(bus.seg), 32'(scan_seg[i/4]));
                check("scan_dp", 32'(bus.dp), 32'((i/4) != 2));
                @(negedge clk_100M);
            end
        end

        // Asynchronous reset mid-cycle at 12:34.
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(bus.count_bcd), 32'h0000);
        check("async_rst_an", 32'(bus.an), 32'hf);
        check("async_rst_seg", 32'(bus.seg), 32'h7f);
        bus.clk_1 = 1'b1;
        #20 bus.clk_1 = 1'b0;
        #20;
        @(negedge clk_100M);
        rst_n = 1'b1;
        sec   = 0;
        repeat (6) @(negedge clk_100M);
        check("no_tick_after_rst", 32'(exp_q.size()), 32'd0);
        check("cnt_after_rst", 32'(bus.count_bcd), 32'h0000);

        // Full wrap.
        while (sec < 3599) do_tick();
        check("cnt_5959", 32'(bus.count_bcd), 32'h5959);
        do_tick();
        check("cnt_wrap", 32'(bus.count_bcd), 32'h0000);

        // run=0 holds the count.
        while (sec < 42) do_tick();
        check("cnt_0042", 32'(bus.count_bcd), 32'h0042);
        bus.run = 1'b0;
        repeat (5) do_tick();
        check("hold_0042", 32'(bus.count_bcd), 32'h0042);
        bus.run = 1'b1;

        // clear coincident with a tick at 00:42.
        sec = 0;
        exp_q.push_back('{count: 16'h0000, roll: 1'b0});
        bus.clk_1 = 1'b1;
        @(negedge clk_100M);
        @(negedge clk_100M);
        bus.clear = 1'b1;
        @(negedge clk_100M);
        bus.clear = 1'b0;
        check("clear_count", 32'(bus.count_bcd), 32'h0000);
        check("clear_roll", 32'(bus.rollover), 32'd0);
        bus.clk_1 = 1'b0;
        repeat (6) @(negedge clk_100M);

        // Drain the scoreboard within a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_100M);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
